// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared widths and record layout for the commit trace buffer
package trace_pkg;

  localparam int STAMP_W = 16;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int REC_W   = STAMP_W + 2 * DATA_W + ADDR_W + 8;

  localparam logic [4:0] X0 = 5'd0;

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic               reg_we;
    logic [4:0]         reg_num;
    logic [DATA_W-1:0]  reg_data;
    logic               mem_wr;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - single-clock show-ahead FIFO with occupancy count
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - timestamps core side effects into a drop-counting trace FIFO
module commit_trace_buffer #(
  parameter int DATA_W  = trace_pkg::DATA_W,
  parameter int ADDR_W  = trace_pkg::ADDR_W,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = trace_pkg::STAMP_W,
  localparam int REC_W  = STAMP_W + 2 * DATA_W + ADDR_W + 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_record,
  output logic [CNT_W-1:0]  fill_level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;
  logic               reg_we_eff, mem_any, evt, pop, push, drop, full, empty;
  logic [REC_W-1:0]   rec;

  assign reg_we_eff = reg_write_sig && (reg_num != trace_pkg::X0);
  assign mem_any    = wr || rd;
  assign evt        = trace_en && (reg_we_eff || mem_any);
  assign pop        = out_valid && out_ready;
  assign push       = evt && (!full || pop);
  assign drop       = evt && full && !pop;

  // Unused fields are zeroed so records compare cleanly; a store wins over a load for mem_data.
  assign rec = {stamp_q,
                reg_we_eff,
                reg_we_eff ? reg_num  : 5'd0,
                reg_we_eff ? reg_data : {DATA_W{1'b0}},
                wr, rd,
                mem_any ? addr : {ADDR_W{1'b0}},
                wr ? wr_data : (rd ? rd_data : {DATA_W{1'b0}})};

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (out_record),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  assign out_valid  = !empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  always_comb begin
    stamp_d      = stamp_q + 1'b1;
    overflow_d   = overflow_q || drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      stamp_q      <= stamp_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;
  import trace_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              trace_en, reg_write_sig, wr, rd, out_ready;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data, wr_data, rd_data;
  logic [ADDR_W-1:0] addr;
  logic              out_valid, overflow;
  logic [REC_W-1:0]  out_record;
  logic [4:0]        fill_level;
  logic [15:0]       drop_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W-1:0] s1, s2, s3, sb, sp;

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
  );

  function automatic trace_rec_t mkrec(input logic [15:0] s, input logic we,
      input logic [4:0] num, input logic [31:0] rdat, input logic mw, input logic mr,
      input logic [8:0] ma, input logic [31:0] md);
    trace_rec_t r;
    r.stamp = s; r.reg_we = we; r.reg_num = num; r.reg_data = rdat;
    r.mem_wr = mw; r.mem_rd = mr; r.mem_addr = ma; r.mem_data = md;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) stamp = stamp + 1'b1;
  endtask

  task automatic idle();
    reg_write_sig = 0; reg_num = 0; reg_data = 0;
    wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0;
  endtask

  initial begin
    reset = 1; trace_en = 1; out_ready = 0; stamp = 0;
    idle();
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);

    // First post-reset cycle carries stamp 0.
    reset = 0; stamp = 0;
    reg_write_sig = 1; reg_num = 5'd1; reg_data = 32'h1111_0000;
    step(); idle();
    chk("first_valid", out_valid, 1);
    chk("first_rec", out_record, mkrec(16'd0, 1, 5'd1, 32'h1111_0000, 0, 0, 0, 0));
    chk("first_fill", fill_level, 1);
    out_ready = 1;
    step();
    chk("first_pop_valid", out_valid, 0);
    chk("first_pop_fill", fill_level, 0);

    step();
    chk("stamp_is_3", stamp, 3);
    reg_write_sig = 1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
    step(); idle();
    chk("rw_valid", out_valid, 1);
    chk("rw_rec", out_record, mkrec(16'd3, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0));
    step();
    chk("rw_pop_fill", fill_level, 0);

    reg_write_sig = 1; reg_num = 5'd0; reg_data = 32'hFFFF;
    step(); idle();
    chk("x0_fill", fill_level, 0);
    trace_en = 0; wr = 1; addr = 9'd5; wr_data = 32'h55;
    step(); idle(); trace_en = 1;
    chk("dis_fill", fill_level, 0);

    out_ready = 0;
    s1 = stamp; wr = 1; addr = 9'h1F0; wr_data = 32'h12345678; rd_data = 32'h0BAD;
    step(); idle();
    s2 = stamp; rd = 1; addr = 9'h0AC; rd_data = 32'hA5A5A5A5; wr_data = 32'h77;
    reg_write_sig = 1; reg_num = 5'd7; reg_data = 32'hA5A5A5A5;
    step(); idle();
    s3 = stamp; wr = 1; rd = 1; addr = 9'h003; wr_data = 32'hCAFE; rd_data = 32'hBEEF;
    step(); idle();
    chk("mem_fill3", fill_level, 3);
    chk("mem_wr_rec", out_record, mkrec(s1, 0, 0, 0, 1, 0, 9'h1F0, 32'h12345678));
    step();
    chk("bp_hold_rec", out_record, mkrec(s1, 0, 0, 0, 1, 0, 9'h1F0, 32'h12345678));
    out_ready = 1;
    step();
    chk("mem_rd_rec", out_record, mkrec(s2, 1, 5'd7, 32'hA5A5A5A5, 0, 1, 9'h0AC, 32'hA5A5A5A5));
    step();
    chk("mem_both_rec", out_record, mkrec(s3, 0, 0, 0, 1, 1, 9'h003, 32'hCAFE));
    step();
    chk("mem_drained", fill_level, 0);

    out_ready = 0; sb = stamp;
    for (int i = 0; i < 20; i++) begin
      wr = 1; addr = 9'(i); wr_data = 32'(i);
      step();
    end
    idle();
    chk("ovf_fill", fill_level, 16);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_record, mkrec(sb, 0, 0, 0, 1, 0, 9'd0, 32'd0));

    out_ready = 1; sp = stamp; wr = 1; addr = 9'h099; wr_data = 32'h99;
    step(); idle();
    chk("fullpp_fill", fill_level, 16);
    chk("fullpp_drop", drop_count, 4);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), out_record,
          mkrec(sb + 16'(i), 0, 0, 0, 1, 0, 9'(i), 32'(i)));
      step();
    end
    chk("drain_last", out_record, mkrec(sp, 0, 0, 0, 1, 0, 9'h099, 32'h99));
    step();
    chk("drain_empty", out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);

    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rd = 1; addr = 9'(i); rd_data = 32'(i);
      step();
    end
    idle();
    chk("pre_rst_fill", fill_level, 5);
    reset = 1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_fill", fill_level, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_drop", drop_count, 0);
    reset = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream observer of the RISC-V core's writeback and data-memory signals: reg_num, reg_data, reg_write_sig, wr, rd, addr, wr_data and rd_data.
- Packs each cycle that has an architectural side effect into a timestamped trace record.
- Buffers records in a FIFO and drains them through a valid/ready port to the fault-injection comparator or a host reader.
- Counts records dropped on overflow and never stalls the core.

Parameters:
DATA_W, 32, width of register and memory data.
ADDR_W, 9, width of the data-memory address.
DEPTH, 16, FIFO entries; power of 2, at least 2.
STAMP_W, 16, width of the cycle timestamp.

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
trace_en  in  1  1 = capture events; 0 = ignore inputs (drain continues).
reg_write_sig  in  1  register-file write strobe from the core.
reg_num  in  5  destination register index.
reg_data  in  DATA_W  data written to the register file.
wr  in  1  data-memory write strobe.
rd  in  1  data-memory read strobe.
addr  in  ADDR_W  data-memory address.
wr_data  in  DATA_W  data-memory store data.
rd_data  in  DATA_W  data-memory load data.
out_valid  out  1  a record is available at the head of the FIFO.
out_ready  in  1  consumer accepts the head record.
out_record  out  REC_W  head record; REC_W = STAMP_W+DATA_W*2+ADDR_W+8 (97 at defaults).
fill_level  out  $clog2(DEPTH)+1  number of occupied entries.
overflow  out  1  sticky flag: at least one record has been dropped.
drop_count  out  16  dropped-record count, saturating.

Behaviour:
- Reset values: out_valid=0, fill_level=0, overflow=0, drop_count=0. Read/write pointers and the stamp counter are 0. out_record content is don't-care until out_valid=1.
- Reset asserted mid-operation: all buffered records are discarded and every output takes its reset value in the next cycle.
- Stamp counter: increments by 1 every non-reset cycle and wraps modulo 2^STAMP_W. A record carries the stamp value of the cycle in which its inputs were sampled.
- Effective register write: reg_we_eff = reg_write_sig && reg_num!=0. Writes to x0 are filtered out.
- Event condition: event = trace_en && (reg_we_eff || wr || rd).
- Record layout, MSB to LSB: stamp[STAMP_W], reg_we, reg_num[5], reg_data[DATA_W], mem_wr, mem_rd, mem_addr[ADDR_W], mem_data[DATA_W].
- Field zeroing and selection:
  - reg_num and reg_data are 0 when reg_we_eff=0.
  - mem_addr and mem_data are 0 when wr=0 and rd=0.
  - mem_data = wr_data if wr=1, else rd_data. If wr and rd are both 1, both flags are set and mem_data = wr_data.
- Pop: pop = out_valid && out_ready.
- Push: push = event && (!full || pop). Popping in the same cycle frees the slot, so a push to a full FIFO is accepted when a pop occurs together with it.
- Drop: occurs when event && full && !pop. Each drop increments drop_count, which saturates at 0xFFFF, and sets overflow. overflow clears only on reset.
- Latency: a record pushed into an empty FIFO gives out_valid=1 in the next cycle. The FIFO is show-ahead: out_record = mem[rd_ptr] whenever out_valid=1.
- Backpressure: while out_valid && !out_ready, out_record and out_valid are held stable.
- fill_level:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Range 0..DEPTH.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. full = (fill_level==DEPTH).
- The core is never back-pressured: no stall output exists.

Decomposition:
- Package trace_pkg holds:
  - the trace_rec_t packed struct in the field order above;
  - STAMP_W and REC_W constants;
  - the X0 index constant (5'd0).
- One natural sub-module, trace_fifo: synchronous single-clock show-ahead FIFO with push/pop/full/empty/count, parameterised on width and DEPTH.
- Event formation, the stamp counter and drop accounting live in commit_trace_buffer.

Test Plan:
- Reset for 2 cycles -> out_valid=0, fill_level=0, overflow=0, drop_count=0. The first record captured after reset carries stamp 0 at the first post-reset cycle.
- reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF, wr=rd=0 at stamp 3; out_ready=1 -> out_valid=1 next cycle with stamp=3, reg_we=1, reg_num=5, reg_data=0xDEADBEEF, all mem fields 0. Popped the following cycle, then fill_level=0.
- reg_write_sig=1, reg_num=0, wr=rd=0 -> no record. Same with trace_en=0 and wr=1 -> no record. fill_level stays 0 in both cases.
- wr=1, addr=0x1F0, wr_data=0x12345678 in one cycle, then rd=1, rd_data=0xA5A5A5A5 with reg_write_sig=1, reg_num=7, reg_data=0xA5A5A5A5 in the next -> two in-order records with mem_wr=1 / mem_rd=1 respectively and correct data.
- out_ready=0, 20 consecutive event cycles, DEPTH=16 -> fill_level=16, drop_count=4, overflow=1. Draining returns the first 16 stamps in order, and overflow remains 1.
- FIFO full, out_ready=1 and event in the same cycle -> push accepted, fill_level stays 16, drop_count unchanged. Separately, reset asserted with fill_level=5 -> next cycle out_valid=0 and fill_level=0.
